dac_sample_queue: RTL
=====================

# dac_sample_queue

Buffers DAC sample values written over the EBI command bus and streams them to the DAC controller one at a time, at a programmable minimum interval. It is a command-bus slave in its own right and sits directly upstream of the DAC controller. It generates that controller's new-value command writes, `{16'h0001, sample}`, and paces them against the controller's `busy` flag. This lets host software queue a burst of samples without polling between writes.

## Interface
- `POSITION`, 65: command-bus slot; block selected when `cmd_bus_addr[15:8] == POSITION`
- `DEPTH`, 16: FIFO entries; power of two
- `TIMEOUT`, 255: `ebi_clk` cycles to wait for DAC busy assertion
- `ebi_clk`  in  1  sole clock
- `nReset`  in  1  reset; asynchronous, active-low
- `cmd_bus_enable`  in  1  bus cycle valid
- `cmd_bus_wr`  in  1  write strobe
- `re`  in  1  read strobe
- `cmd_bus_addr`  in  16  [15:8] slot, [7:0] register offset
- `cmd_bus_data`  in  32  write data
- `out_data`  out  16  read data; 0 when not being read
- `dac_busy`  in  1  busy from DAC controller; sclk domain, asynchronous here
- `dac_cmd_wr`  out  1  one-cycle write strobe to DAC controller
- `dac_cmd_data`  out  32  `{16'h0001, sample}`; held stable from strobe until next issue

## Operation
- Register offsets (write):
  - 0 SAMPLE: push `cmd_bus_data[15:0]`
  - 1 CTRL: bit0 enable, bit1 clear (self-clearing pulse)
  - 2 PERIOD: `[15:0]`
- Register offsets (read):
  - 3 STATUS: `{7'b0, timeout_err, overflow, full, empty, count[4:0]}`
  - 9 ID: `16'h0DA5`
  - Any other offset reads 0.
- Push when full: the sample is dropped and sticky `overflow` is set. `count` saturates at DEPTH.
- Push and pop in the same cycle: both take effect and `count` is unchanged. Push to an empty FIFO with a simultaneous pop is not possible, because a pop requires `!empty` in the previous cycle.
- Clear flushes the FIFO (`count=0`) and clears `overflow` and `timeout_err`. It does not abort an in-flight transfer. If clear and push occur together, clear wins.
- `dac_busy` passes through a 2-flop synchroniser → `busy_s`.
- FSM:
  - **IDLE**: if `enable & !empty`, pop the head into `dac_cmd_data[15:0]` and go to ISSUE.
  - **ISSUE**: `dac_cmd_wr=1` for exactly one cycle, load the timeout counter, go to WAIT_BUSY.
  - **WAIT_BUSY**: if `busy_s`, go to WAIT_IDLE. If the timeout counter reaches 0, set `timeout_err` and go to PACE.
  - **WAIT_IDLE**: when `!busy_s`, load the pace counter with PERIOD and go to PACE.
  - **PACE**: count down. At 0 go to IDLE; PERIOD=0 means one cycle in PACE.
- Disabling mid-transfer lets the current sample finish; the block then holds in IDLE.

## Timing
- Reset values:
  - `out_data=0`, `dac_cmd_wr=0`, `dac_cmd_data=32'h0001_0000`, FSM in IDLE
  - `enable=0`, `PERIOD=0`, FIFO empty, stickies 0, synchroniser 0
- `nReset` asserted mid-transfer clears everything immediately. No further strobe is issued, and queued samples are lost.
- `out_data` is registered: it is valid one cycle after `cs & re` and returns to 0 the cycle after `re` drops.
- A push is visible in STATUS.count one cycle after the write.
- Minimum spacing between strobes is 1 (IDLE) + 1 (ISSUE) + 2 (synchroniser) + DAC busy time + PERIOD+1 cycles.
- `dac_cmd_data` changes only on the IDLE→ISSUE transition.

## Structure
- Package `dac_pkg`:
  - `DAC_CMD_NEW_VALUE=16'h0001`
  - register offset constants
  - ID constant `16'h0DA5`
  - FSM state encoding (one-hot, 5 bits)
- Sub-module `sample_fifo`: synchronous FIFO of DEPTH×16 with push, pop, clear, count, full and empty. Clear has priority over push.

## Test plan
- Enable, PERIOD=0, push 0x1234, model busy high for 20 cycles → one `dac_cmd_wr` pulse with `dac_cmd_data=0x00011234`, then the FSM returns to IDLE.
- Push 17 samples while disabled → STATUS reads `count=16`, `full=1`, `overflow=1`; after enable, exactly 16 strobes come out in FIFO order.
- PERIOD=100 with 3 queued samples → the gap from busy falling to the next strobe is ≥101 cycles.
- Hold `dac_busy` low → `timeout_err` is set after TIMEOUT cycles and the next sample still issues; CTRL clear resets the sticky.
- Assert `nReset` in WAIT_IDLE with 5 queued samples → all outputs take reset values immediately and no strobe follows the release of reset.
- Read offset 9 → `out_data=0x0DA5` one cycle later; read offset 7 → 0; a read at another slot → 0.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared constants and FSM encoding for the DAC sample queue.
package dac_pkg;

  localparam logic [15:0] DAC_CMD_NEW_VALUE = 16'h0001;
  localparam logic [15:0] DAC_ID            = 16'h0DA5;

  localparam logic [7:0] OFF_SAMPLE = 8'd0;
  localparam logic [7:0] OFF_CTRL   = 8'd1;
  localparam logic [7:0] OFF_PERIOD = 8'd2;
  localparam logic [7:0] OFF_STATUS = 8'd3;
  localparam logic [7:0] OFF_ID     = 8'd9;

  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StIssue    = 5'b00010,
    StWaitBusy = 5'b00100,
    StWaitIdle = 5'b01000,
    StPace     = 5'b10000
  } dac_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous DEPTH x Width FIFO with flush; flush takes priority over push.
module sample_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [Width-1:0]           data_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = AddrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CountW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CountW'(push_ok) - CountW'(pop_ok);
    end
  end

endmodule

// File: rtl/dac_sample_queue.sv
// Command-bus slave that queues DAC samples and paces new-value writes to the DAC controller.
module dac_sample_queue #(
  parameter int unsigned POSITION = 65,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        ebi_clk,
  input  logic        nReset,
  input  logic        cmd_bus_enable,
  input  logic        cmd_bus_wr,
  input  logic        re,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  output logic [15:0] out_data,
  input  logic        dac_busy,
  output logic        dac_cmd_wr,
  output logic [31:0] dac_cmd_data
);
  import dac_pkg::*;

  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam int unsigned TmoW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [7:0]  Slot   = 8'(POSITION);

  logic              cs, bus_wr, bus_rd, push, pop, clear;
  logic [7:0]        offset;
  logic [15:0]       fifo_head, rd_data;
  logic [CountW-1:0] fifo_count;
  logic              fifo_full, fifo_empty;
  logic              unused_data;

  logic              enable_q, overflow_q, timeout_err_q;
  logic [15:0]       period_q, pace_q, out_data_q;
  logic              busy_meta_q, busy_s_q;
  dac_state_e        state_q;
  logic              dac_cmd_wr_q;
  logic [31:0]       dac_cmd_data_q;
  logic [TmoW-1:0]   tmo_q;

  assign cs          = cmd_bus_enable && (cmd_bus_addr[15:8] == Slot);
  assign offset      = cmd_bus_addr[7:0];
  assign bus_wr      = cs && cmd_bus_wr;
  assign bus_rd      = cs && re;
  assign push        = bus_wr && (offset == OFF_SAMPLE);
  assign clear       = bus_wr && (offset == OFF_CTRL) && cmd_bus_data[1];
  assign pop         = (state_q == StIdle) && enable_q && !fifo_empty;
  assign unused_data = ^cmd_bus_data[31:16];

  sample_fifo #(
    .Depth (DEPTH),
    .Width (16)
  ) u_fifo (
    .clk_i   (ebi_clk),
    .rst_ni  (nReset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .data_i  (cmd_bus_data[15:0]),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rd_data = '0;
    case (offset)
      OFF_STATUS: rd_data = {7'b0, timeout_err_q, overflow_q, fifo_full, fifo_empty,
                             5'(fifo_count)};
      OFF_ID:     rd_data = DAC_ID;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) begin
      enable_q    <= 1'b0;
      period_q    <= '0;
      overflow_q  <= 1'b0;
      out_data_q  <= '0;
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      if (bus_wr && (offset == OFF_CTRL))   enable_q <= cmd_bus_data[0];
      if (bus_wr && (offset == OFF_PERIOD)) period_q <= cmd_bus_data[15:0];
      if (clear)                  overflow_q <= 1'b0;
      else if (push && fifo_full) overflow_q <= 1'b1;
      out_data_q  <= bus_rd ? rd_data : '0;
      busy_meta_q <= dac_busy;
      busy_s_q    <= busy_meta_q;
    end
  end

  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) begin
      state_q        <= StIdle;
      dac_cmd_wr_q   <= 1'b0;
      dac_cmd_data_q <= {DAC_CMD_NEW_VALUE, 16'h0000};
      tmo_q          <= '0;
      pace_q         <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      dac_cmd_wr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            dac_cmd_data_q <= {DAC_CMD_NEW_VALUE, fifo_head};
            dac_cmd_wr_q   <= 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
          tmo_q   <= TmoW'(TIMEOUT);
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (busy_s_q) begin
            state_q <= StWaitIdle;
          end else if (tmo_q == '0) begin
            timeout_err_q <= 1'b1;
            pace_q        <= period_q;
            state_q       <= StPace;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        StWaitIdle: begin
          if (!busy_s_q) begin
            pace_q  <= period_q;
            state_q <= StPace;
          end
        end
        StPace: begin
          if (pace_q == '0) state_q <= StIdle;
          else              pace_q  <= pace_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
      // A clear in the same cycle as a timeout leaves the sticky cleared.
      if (clear) timeout_err_q <= 1'b0;
    end
  end

  assign out_data     = out_data_q;
  assign dac_cmd_wr   = dac_cmd_wr_q;
  assign dac_cmd_data = dac_cmd_data_q;

endmodule
